t02_ram_bus_adapter: RTL
========================

Name: t02_ram_bus_adapter

Overview:
Downstream stage of the t02 CPU top level. It takes the CPU's word-wide RAM request interface (ramaddr, ramstore, Ren, Wen) and turns each request into one classic Wishbone single transfer on the shared SoC bus. It returns ramload and busy_o to the CPU. It also adds a bus-timeout watchdog so that an absent slave cannot hang the core.

Parameters:
TIMEOUT, 255, cycles waited in BUS state for wb_ack_i before the transfer is aborted (1..65535)
ERR_DATA, 32'hDEAD_BEEF, value placed on ramload when a read times out

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
ramaddr  input  32  CPU byte address
ramstore  input  32  CPU write data
Ren  input  1  CPU read request, level, held until busy_o falls
Wen  input  1  CPU write request, level, held until busy_o falls
ramload  output  32  read data returned to CPU
busy_o  output  1  transfer in progress
wb_cyc_o  output  1  Wishbone cycle
wb_stb_o  output  1  Wishbone strobe
wb_we_o  output  1  Wishbone write enable
wb_adr_o  output  32  word-aligned bus address
wb_dat_o  output  32  bus write data
wb_sel_o  output  4  byte selects
wb_dat_i  input  32  bus read data
wb_ack_i  input  1  bus acknowledge
err_o  output  1  sticky timeout flag

Behaviour:
- Clocking and reset: single clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; ramload=0; err_o=0; wb_cyc_o, wb_stb_o and wb_we_o =0; wb_adr_o and wb_dat_o =0; wb_sel_o=0; timeout counter=0.
- States: IDLE, BUS, DONE.
- IDLE:
  - If Ren or Wen is high, accept the request.
  - Latch wb_adr_o={ramaddr[31:2],2'b00}, wb_dat_o=ramstore, wb_we_o=Wen, wb_sel_o=4'hF.
  - Clear the counter and go to BUS.
  - Ren and Wen both high: the write takes priority and the read is dropped.
- BUS:
  - wb_cyc_o and wb_stb_o are high.
  - On wb_ack_i: if the transfer is a read, ramload<=wb_dat_i; go to DONE.
  - No ack: counter increments. When the counter reaches TIMEOUT-1 without an ack:
    - drop cyc/stb;
    - set err_o=1;
    - if the transfer is a read, ramload<=ERR_DATA;
    - go to DONE.
  - An ack in the same cycle as the timeout wins, and err_o is not set.
- DONE:
  - Lasts exactly one cycle with cyc/stb low and no new acceptance. The CPU samples completion here.
  - Then IDLE. A still-asserted request in IDLE starts a new transfer.
- busy_o is combinational: high in BUS; high in IDLE when Ren or Wen is high; low in DONE; low in IDLE with no request.
- ramload holds its value until the next read completes. Writes never change ramload.
- err_o is sticky and is cleared only by rst.
- Latched request fields are stable for the whole BUS phase. Changes on the CPU inputs during BUS are ignored.
- Minimum latency:
  - request seen in IDLE at cycle 0;
  - cyc/stb high at cycle 1;
  - ack at cycle 1 gives DONE at cycle 2, with busy_o low and ramload valid.
- wb_ack_i outside BUS is ignored.
- rst during BUS drops cyc/stb on the next edge. No error is flagged.

Decomposition:
- Shared package t02_pkg holds:
  - state enum bus_state_t {IDLE, BUS, DONE};
  - constant WORD_SEL=4'hF;
  - default constants for TIMEOUT and ERR_DATA.
- Natural sub-module: t02_bus_watchdog. It is a loadable down-counter with a clear input and an expiry output, parameterised by TIMEOUT.

Test Plan:
1. Read, ack after 1 cycle: Ren=1, ramaddr=32'h0000_1006, slave returns 32'hCAFE_0001 -> wb_adr_o=32'h0000_1004, wb_we_o=0, wb_sel_o=4'hF; busy_o low at cycle 2; ramload=32'hCAFE_0001; err_o=0.
2. Write, ack after 5 cycles: Wen=1, ramstore=32'h1234_5678 -> wb_we_o=1 and wb_dat_o=32'h1234_5678 held stable through all 5 BUS cycles; ramload unchanged; busy_o low only in DONE.
3. Timeout with TIMEOUT=8 and no ack on a read -> cyc/stb drop after 8 BUS cycles; err_o=1 (sticky); ramload=32'hDEAD_BEEF; a following read with a prompt ack still completes, and err_o stays 1.
4. Ren and Wen both high -> a single write transfer (wb_we_o=1) and no read.
5. Back-to-back: Ren held high across DONE -> exactly one DONE cycle with busy_o=0, then a second transfer starts; a spurious wb_ack_i in IDLE has no effect.
6. rst=1 during BUS -> next cycle: IDLE, all outputs at reset values, err_o=0.

Source files
------------

// File: rtl/t02_pkg.sv
// Shared types and constants for the t02 RAM-to-Wishbone bus adapter.
package t02_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned WD_W   = 16;

  localparam logic [SEL_W-1:0]  WORD_SEL     = 4'hF;
  localparam int unsigned       T02_TIMEOUT  = 255;
  localparam logic [DATA_W-1:0] T02_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } bus_state_t;

  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/t02_bus_watchdog.sv
// Loadable down-counter; expired_o is high once TIMEOUT-1 enabled cycles follow a clear.
module t02_bus_watchdog
  import t02_pkg::*;
#(
  parameter int unsigned TIMEOUT = T02_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [WD_W-1:0] cnt_q, cnt_d;
  logic            expired_q;

  // Counter saturates at zero; expiry is registered from the next count value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = WD_W'(TIMEOUT - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == '0);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/t02_ram_bus_adapter.sv
// Turns CPU word RAM requests into single classic Wishbone transfers, with a bus timeout.
module t02_ram_bus_adapter
  import t02_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = T02_TIMEOUT,
  parameter logic [DATA_W-1:0] ERR_DATA = T02_ERR_DATA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ramaddr,
  input  logic [DATA_W-1:0] ramstore,
  input  logic              Ren,
  input  logic              Wen,
  output logic [DATA_W-1:0] ramload,
  output logic              busy_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  output logic              err_o
);

  bus_state_t        state_q, state_d;
  wb_req_t           req_q, req_d;
  logic              cyc_q, cyc_d;
  logic [DATA_W-1:0] ramload_q, ramload_d;
  logic              err_q, err_d;
  logic              wd_clear_c, wd_en_c, wd_expired;
  logic [1:0]        unused_addr_lsb;

  assign unused_addr_lsb = ramaddr[1:0];

  t02_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (wd_clear_c),
    .en_i     (wd_en_c),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      cyc_q     <= 1'b0;
      ramload_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cyc_q     <= cyc_d;
      ramload_q <= ramload_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cyc_d      = cyc_q;
    ramload_d  = ramload_q;
    err_d      = err_q;
    wd_clear_c = 1'b0;
    wd_en_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Write wins when both requests are raised together.
        if (Ren || Wen) begin
          req_d.we   = Wen;
          req_d.sel  = WORD_SEL;
          req_d.adr  = {ramaddr[ADDR_W-1:2], 2'b00};
          req_d.dat  = ramstore;
          cyc_d      = 1'b1;
          wd_clear_c = 1'b1;
          state_d    = BUS;
        end
      end
      BUS: begin
        wd_en_c = 1'b1;
        if (wb_ack_i) begin
          if (!req_q.we) ramload_d = wb_dat_i;
          cyc_d   = 1'b0;
          state_d = DONE;
        end else if (wd_expired) begin
          if (!req_q.we) ramload_d = ERR_DATA;
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o   = (state_q == BUS) || ((state_q == IDLE) && (Ren || Wen));
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = req_q.we;
  assign wb_sel_o = req_q.sel;
  assign wb_adr_o = req_q.adr;
  assign wb_dat_o = req_q.dat;
  assign ramload  = ramload_q;
  assign err_o    = err_q;

endmodule
